// File: rtl/dbus_mem_responder_pkg.sv
// Shared data-bus types, the memory-access FSM state type and helpers for the data-bus responder.
package dbus_mem_responder_pkg;

    localparam int DBUS_LAT_W = 4;

    typedef logic [63:0] word_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        word_t       data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        MEM_IDLE    = 2'd0,
        MEM_WAITING = 2'd1,
        MEM_OVER    = 2'd2
    } mem_access_state_t;

    function automatic logic [3:0] size_bytes(input msize_t s);
        return 4'd1 << s[1:0];
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] b);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'b0, b[i]};
        return c;
    endfunction

endpackage

// File: rtl/dbus_ram.sv
// Word-organised RAM: byte-enabled synchronous write, read registered on the access cycle.
module dbus_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_access,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [7:0]    i_be,
    input  logic [AW-1:0] i_idx,
    input  logic [63:0]   i_wdata,
    output logic [63:0]   o_rdata
);

    logic [63:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 8; b++) begin
                if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Writes and out-of-range reads return zero.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)      o_rdata <= '0;
        else if (i_access) o_rdata <= i_re ? r_mem[i_idx] : '0;
    end

endmodule

// File: rtl/dbus_mem_responder.sv
// Data-bus responder: IDLE/WAITING/OVER FSM with LATENCY wait states in front of dbus_ram.
// Optional protocol/alignment checking on resp_err under DBUS_RESP_CHECK_EN.
module dbus_mem_responder
    import dbus_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    input  logic [63:0] i_req_addr,
    input  logic [2:0]  i_req_size,
    input  logic [7:0]  i_req_strobe,
    input  logic [63:0] i_req_data,
    output logic        o_resp_addr_ok,
    output logic        o_resp_data_ok,
    output logic [63:0] o_resp_data,
    output logic        o_resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    mem_access_state_t     r_state, w_state_nx;
    logic [DBUS_LAT_W-1:0] r_cnt, w_cnt_nx;
    dbus_req_t             r_req;
    dbus_resp_t            w_resp;
    logic                  w_capture, w_access, w_in_range;
    logic [63:0]           w_off, w_rdata;
    logic [AW-1:0]         w_idx;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= MEM_IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_capture) begin
                r_req <= '{addr: i_req_addr, size: msize_t'(i_req_size),
                           strobe: i_req_strobe, data: i_req_data};
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_capture  = 1'b0;
        w_access   = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                if (i_req_valid) begin
                    w_capture  = 1'b1;
                    w_cnt_nx   = DBUS_LAT_W'(LATENCY);
                    w_state_nx = MEM_WAITING;
                end
            end
            MEM_WAITING: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else begin
                    w_access   = 1'b1;
                    w_state_nx = MEM_OVER;
                end
            end
            MEM_OVER: w_state_nx = MEM_IDLE;
            default:  w_state_nx = MEM_IDLE;
        endcase
    end

    // Offset compare avoids overflow of BASE_ADDR + 8*DEPTH_WORDS.
    assign w_off      = r_req.addr - BASE_ADDR;
    assign w_in_range = (r_req.addr >= BASE_ADDR) && (w_off < (64'(DEPTH_WORDS) << 3));
    assign w_idx      = w_off[AW+2:3];

    dbus_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_access (w_access),
        .i_we     (w_access && w_in_range && (r_req.strobe != 8'h00)),
        .i_re     (w_in_range && (r_req.strobe == 8'h00)),
        .i_be     (r_req.strobe),
        .i_idx    (w_idx),
        .i_wdata  (r_req.data),
        .o_rdata  (w_rdata)
    );

    assign w_resp.addr_ok = (r_state == MEM_OVER);
    assign w_resp.data_ok = (r_state == MEM_OVER);
    assign w_resp.data    = (r_state == MEM_OVER) ? w_rdata : '0;

    assign o_resp_addr_ok = w_resp.addr_ok;
    assign o_resp_data_ok = w_resp.data_ok;
    assign o_resp_data    = w_resp.data;

`ifdef DBUS_RESP_CHECK_EN
    logic r_drop, r_err, w_misalign, w_bad_strb, w_err;

    always_comb begin
        case (r_req.size)
            MSIZE2:  w_misalign = r_req.addr[0];
            MSIZE4:  w_misalign = |r_req.addr[1:0];
            MSIZE8:  w_misalign = |r_req.addr[2:0];
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_bad_strb = (r_req.strobe != 8'h00) && (popcount8(r_req.strobe) != size_bytes(r_req.size));
    assign w_err      = !w_in_range || w_misalign || w_bad_strb || r_drop || !i_req_valid;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_drop <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_capture)                                      r_drop <= 1'b0;
            else if (r_state == MEM_WAITING && !i_req_valid)    r_drop <= 1'b1;
            if (w_access) begin
                r_err <= w_err;
                if (w_err) $error("dbus_mem_responder: bad access addr=%h size=%0d strobe=%h",
                                  r_req.addr, r_req.size, r_req.strobe);
            end
        end
    end

    assign o_resp_err = (r_state == MEM_OVER) && r_err;
`else
    logic w_unused_size;
    assign w_unused_size = ^r_req.size;
    assign o_resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Directed bench for dbus_mem_responder: LATENCY=2 (u0) and LATENCY=0 (u1) instances.
module tb_dbus_mem_responder;
    import dbus_mem_responder_pkg::*;

`ifdef DBUS_RESP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [63:0] addr = '0, wdata = '0;
    logic [2:0]  size = '0;
    logic [7:0]  strb = '0;
    logic        aok0, dok0, err0, aok1, dok1, err1;
    logic [63:0] rdat0, rdat1;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    dbus_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(64'h8000_0000)) u0 (
        .i_clk(clk), .i_reset(rst_n), .i_req_valid(v0), .i_req_addr(addr),
        .i_req_size(size), .i_req_strobe(strb), .i_req_data(wdata),
        .o_resp_addr_ok(aok0), .o_resp_data_ok(dok0), .o_resp_data(rdat0), .o_resp_err(err0));

    dbus_mem_responder #(.DEPTH_WORDS(16), .LATENCY(0), .BASE_ADDR(64'h8000_0000)) u1 (
        .i_clk(clk), .i_reset(rst_n), .i_req_valid(v1), .i_req_addr(addr),
        .i_req_size(size), .i_req_strobe(strb), .i_req_data(wdata),
        .o_resp_addr_ok(aok1), .o_resp_data_ok(dok1), .o_resp_data(rdat1), .o_resp_err(err1));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Single transaction; valid dropped right after the data_ok cycle is sampled.
    task automatic do_req(input bit sel, input string tag, input logic [63:0] a, input msize_t s,
                          input logic [7:0] st, input logic [63:0] d,
                          input logic [63:0] exp_data, input bit exp_err);
        int  n;
        bit  seen;
        logic [63:0] dat;
        logic aok, err;
        n = 0; seen = 1'b0; dat = '0; aok = 1'b0; err = 1'b0;
        @(posedge clk); #1;
        addr = a; size = s; strb = st; wdata = d;
        if (sel) v1 = 1'b1; else v0 = 1'b1;
        while (!seen && n < 50) begin
            @(posedge clk); #1;
            n++;
            if (sel ? dok1 : dok0) begin
                seen = 1'b1;
                dat  = sel ? rdat1 : rdat0;
                aok  = sel ? aok1 : aok0;
                err  = sel ? err1 : err0;
            end
        end
        v0 = 1'b0; v1 = 1'b0;
        chk({tag, "_lat"},  64'(n), sel ? 64'd2 : 64'd4);
        chk({tag, "_aok"},  64'(aok), 64'(seen));
        chk({tag, "_data"}, dat, exp_data);
        chk({tag, "_err"},  64'(err), 64'(exp_err));
    endtask

    // Valid held across three reads; pulses must be exactly lat+3 apart, first at lat+2.
    task automatic b2b(input bit sel, input string tag, input logic [63:0] a,
                       input logic [63:0] exp_data, input int lat);
        int t[$];
        @(posedge clk); #1;
        addr = a; size = MSIZE8; strb = 8'h00; wdata = '0;
        if (sel) v1 = 1'b1; else v0 = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (sel ? dok1 : dok0) begin
                t.push_back(cyc);
                chk({tag, "_data"}, sel ? rdat1 : rdat0, exp_data);
                if (t.size() == 3) begin v0 = 1'b0; v1 = 1'b0; end
            end
        end
        v0 = 1'b0; v1 = 1'b0;
        chk({tag, "_npulse"}, 64'(t.size()), 64'd3);
        if (t.size() == 3) begin
            chk({tag, "_first"}, 64'(t[0]), 64'(lat + 2));
            chk({tag, "_gap1"},  64'(t[1] - t[0]), 64'(lat + 3));
            chk({tag, "_gap2"},  64'(t[2] - t[1]), 64'(lat + 3));
        end
    endtask

    initial begin
        // Reset held with valid asserted: no response may appear
        v0 = 1'b1; v1 = 1'b1; addr = 64'h8000_0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rst_out0", {61'b0, aok0, dok0, err0}, 64'd0);
            chk("rst_out1", {61'b0, aok1, dok1, err1}, 64'd0);
        end
        chk("rst_data0", rdat0, 64'd0);
        v0 = 1'b0; v1 = 1'b0;
        rst_n = 1'b1;

        do_req(0, "wr_sd",  64'h8000_0010, MSIZE8, 8'hFF, 64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0);
        do_req(0, "rd_sd",  64'h8000_0010, MSIZE8, 8'h00, 64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0);

        do_req(0, "wr_z",   64'h8000_0018, MSIZE8, 8'hFF, 64'h0, 64'h0, 1'b0);
        do_req(0, "wr_sb",  64'h8000_0018, MSIZE1, 8'h40, 64'h00AB_0000_0000_0000, 64'h0, 1'b0);
        do_req(0, "rd_sb",  64'h8000_0018, MSIZE8, 8'h00, 64'h0, 64'h00AB_0000_0000_0000, 1'b0);

        do_req(0, "wr_pat", 64'h8000_0020, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 1'b0);
        do_req(0, "wr_b0",  64'h8000_0020, MSIZE1, 8'h01, 64'h0000_0000_0000_00FF, 64'h0, 1'b0);
        do_req(0, "rd_b0",  64'h8000_0020, MSIZE8, 8'h00, 64'h0, 64'h1122_3344_5566_77FF, 1'b0);

        do_req(0, "rd_low", 64'h7FFF_FFF8, MSIZE8, 8'h00, 64'h0, 64'h0, CHK);
        do_req(0, "wr_top", 64'h8000_1FF8, MSIZE8, 8'hFF, 64'hCAFE_F00D_5555_AAAA, 64'h0, 1'b0);
        do_req(0, "wr_oor", 64'h8000_2000, MSIZE8, 8'hFF, 64'h1234_5678_9ABC_DEF0, 64'h0, CHK);
        do_req(0, "rd_oor", 64'h8000_2000, MSIZE8, 8'h00, 64'h0, 64'h0, CHK);
        do_req(0, "rd_top", 64'h8000_1FF8, MSIZE8, 8'h00, 64'h0, 64'hCAFE_F00D_5555_AAAA, 1'b0);

        do_req(0, "wr_w0",  64'h8000_0000, MSIZE8, 8'hFF, 64'h1111_1111_1111_1111, 64'h0, 1'b0);
        do_req(0, "wr_sw",  64'h8000_0002, MSIZE4, 8'h3C, 64'h0000_A1B2_C3D4_0000, 64'h0, CHK);
        do_req(0, "rd_sw",  64'h8000_0000, MSIZE8, 8'h00, 64'h0, 64'h1111_A1B2_C3D4_1111, 1'b0);

        b2b(0, "b2b_l2", 64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 2);

        do_req(1, "l0_wr",  64'h8000_0008, MSIZE8, 8'hFF, 64'h0F0F_0F0F_A5A5_5A5A, 64'h0, 1'b0);
        do_req(1, "l0_rd",  64'h8000_0008, MSIZE8, 8'h00, 64'h0, 64'h0F0F_0F0F_A5A5_5A5A, 1'b0);
        do_req(1, "l0_oor", 64'h8000_0080, MSIZE8, 8'h00, 64'h0, 64'h0, CHK);
        b2b(1, "b2b_l0", 64'h8000_0008, 64'h0F0F_0F0F_A5A5_5A5A, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
